hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the ID-stage hazard detector for the ARM pipeline.
- Replaces the direct EXE_Dest/MEM_Dest comparison with a per-register scoreboard of pending-write countdowns, so pipeline depth is a parameter rather than hard-wired.
- Supports two modes: no-forwarding (stall until writeback) and forwarding (stall only on load-use).
- Keeps a saturating stall-cycle counter for performance reporting.

Parameters:
- REG_ADDR_W, 4: register address width; NUM_REGS = 2**REG_ADDR_W.
- WB_LATENCY, 2: cycles from an issue leaving ID until its result is readable from the register file (no-forwarding mode); legal range 1..7.
- LOAD_USE_STALL, 1: stall cycles a consumer needs after a load in forwarding mode; legal range 1..7, must be <= WB_LATENCY.
- STALL_CNT_W, 16: width of Stall_Cnt.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-low; clears all state.
- src1  in  REG_ADDR_W  first source register of the instruction in ID.
- src2  in  REG_ADDR_W  second source register of the instruction in ID.
- Two_src  in  1  src2 is a real operand.
- Issue_Valid  in  1  the instruction in ID leaves ID this cycle, if not stalled.
- Dest  in  REG_ADDR_W  destination register of the issuing instruction.
- WB_EN  in  1  the issuing instruction writes Dest.
- MEM_R_EN  in  1  the issuing instruction is a load.
- Forward_EN  in  1  mode select: 1 = forwarding, 0 = no-forwarding; static outside reset.
- Freeze  in  1  whole pipeline frozen (memory wait); scoreboard holds.
- Flush  in  1  instructions behind ID are squashed (taken branch); scoreboard clears.
- Hazard  out  1  stall ID this cycle.
- Stall_Cnt  out  STALL_CNT_W  saturating count of cycles with Hazard=1.

Behaviour:
- State:
  - wb_cnt[r] for each register, 3 bits: cycles until the write to r is readable.
  - ld_cnt[r] for each register, 3 bits: remaining load-use stall cycles for r.
- Reset (rst=0, asynchronous): all wb_cnt and ld_cnt = 0 and Stall_Cnt = 0. Hazard is therefore 0 during reset.
- Hazard is combinational from current state, with zero latency:
  - busy(r) = (Forward_EN ? ld_cnt[r] : wb_cnt[r]) != 0.
  - Hazard = busy(src1) | (Two_src & busy(src2)).
  - src1 is always checked, matching the prior unit.
- accept = Issue_Valid & ~Hazard & ~Freeze & ~Flush.
- Per-register update each cycle, for every r. Priority is Flush > Freeze > load > decrement.
  - Flush=1: wb_cnt[r] = 0 and ld_cnt[r] = 0.
  - Else if Freeze=1: hold.
  - Else, if accept & WB_EN & (Dest == r):
    - wb_cnt[r] = WB_LATENCY.
    - ld_cnt[r] = MEM_R_EN ? LOAD_USE_STALL : 0.
  - Else: each nonzero counter decrements by 1; counters floor at 0 and never wrap.
- Same-register reload while still pending: the new issue value overwrites the old one (the newest writer wins). No accumulation.
- Issue with Hazard=1: nothing is recorded, because the stalled instruction is re-presented next cycle.
- Issue with WB_EN=0: nothing is recorded.
- Stall_Cnt:
  - Increments by 1 on each cycle where Hazard=1 and Flush=0.
  - Saturates at all-ones.
  - Freeze does not block counting.
- Forward_EN changes take effect combinationally. Both counter sets are always maintained, so switching modes mid-run is safe.
- Reset asserted mid-operation clears everything immediately. The first post-reset cycle sees no hazards.

Test Plan:
- No-forwarding RAW: Forward_EN=0, WB_LATENCY=2; issue Dest=3, WB_EN=1 at cycle 0; present src1=3 at cycles 1, 2, 3 -> Hazard=1,1,0; Stall_Cnt=2.
- Forwarding load-use: Forward_EN=1; issue load Dest=5 (MEM_R_EN=1) -> next cycle src2=5, Two_src=1 gives Hazard=1 for exactly 1 cycle. A non-load Dest=5 -> Hazard=0.
- Two_src gating: wb_cnt[7] pending; src2=7 with Two_src=0 -> Hazard=0; with Two_src=1 -> Hazard=1. src1=7 -> Hazard=1 regardless of Two_src.
- Freeze and Flush:
  - Issue Dest=2, then Freeze=1 for 3 cycles -> Hazard on src1=2 stays 1 throughout, and Stall_Cnt rises by 3.
  - A one-cycle Flush -> Hazard=0 the next cycle.
- Overwrite and saturation: issue Dest=4, then one cycle later issue a load Dest=4 -> wb_cnt[4] reloads to 2. Force Hazard for 2**16+5 cycles -> Stall_Cnt=16'hFFFF.
- Async reset: assert rst=0 mid-stall, between clock edges -> Hazard=0 and Stall_Cnt=0 immediately; after release, src1=any -> Hazard=0.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard detector built on a per-register scoreboard of pending-write
// countdowns; supports forwarding (load-use only) and no-forwarding modes.
module hazard_scoreboard #(
    parameter int REG_ADDR_W     = 4,
    parameter int WB_LATENCY     = 2,
    parameter int LOAD_USE_STALL = 1,
    parameter int STALL_CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [REG_ADDR_W-1:0]  src1,
    input  logic [REG_ADDR_W-1:0]  src2,
    input  logic                   Two_src,
    input  logic                   Issue_Valid,
    input  logic [REG_ADDR_W-1:0]  Dest,
    input  logic                   WB_EN,
    input  logic                   MEM_R_EN,
    input  logic                   Forward_EN,
    input  logic                   Freeze,
    input  logic                   Flush,
    output logic                   Hazard,
    output logic [STALL_CNT_W-1:0] Stall_Cnt
);
    localparam int NUM_REGS = 2 ** REG_ADDR_W;
    localparam logic [2:0] WB_LOAD = 3'(WB_LATENCY);
    localparam logic [2:0] LU_LOAD = 3'(LOAD_USE_STALL);

    logic [NUM_REGS-1:0][2:0] wb_cnt;
    logic [NUM_REGS-1:0][2:0] ld_cnt;
    logic [NUM_REGS-1:0]      busy;
    logic                     accept;

    // src1 is always checked, even for instructions that do not really read it.
    assign Hazard = busy[src1] | (Two_src & busy[src2]);
    assign accept = Issue_Valid & ~Hazard & ~Freeze & ~Flush;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        logic       hit;
        logic [2:0] wb_q;
        logic [2:0] ld_q;

        assign hit       = accept & WB_EN & (Dest == REG_ADDR_W'(r));
        assign wb_cnt[r] = wb_q;
        assign ld_cnt[r] = ld_q;
        assign busy[r]   = Forward_EN ? (ld_q != 3'd0) : (wb_q != 3'd0);

        // Both counter sets always run so a mode switch mid-run stays correct.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                wb_q <= 3'd0;
                ld_q <= 3'd0;
            end else if (Flush) begin
                wb_q <= 3'd0;
                ld_q <= 3'd0;
            end else if (!Freeze) begin
                if (hit) begin
                    wb_q <= WB_LOAD;
                    ld_q <= MEM_R_EN ? LU_LOAD : 3'd0;
                end else begin
                    wb_q <= (wb_q != 3'd0) ? wb_q - 3'd1 : 3'd0;
                    ld_q <= (ld_q != 3'd0) ? ld_q - 3'd1 : 3'd0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Stall_Cnt <= '0;
        end else if (Hazard && !Flush && (Stall_Cnt != {STALL_CNT_W{1'b1}})) begin
            Stall_Cnt <= Stall_Cnt + STALL_CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus randomized traffic
// checked against an integer per-register countdown model.
module tb_hazard_scoreboard;
    localparam int AW   = 4;
    localparam int NR   = 2 ** AW;
    localparam int WBL  = 2;
    localparam int LUS  = 1;
    localparam int SCW  = 16;
    localparam int SMAX = 2 ** SCW - 1;

    logic           clk = 1'b0;
    logic           rst;
    logic [AW-1:0]  src1, src2, Dest;
    logic           Two_src, Issue_Valid, WB_EN, MEM_R_EN, Forward_EN, Freeze, Flush;
    logic           Hazard;
    logic [SCW-1:0] Stall_Cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    // model state: pending-write and load-use countdowns per register
    int m_wb[NR];
    int m_ld[NR];
    int m_scnt;

    hazard_scoreboard #(
        .REG_ADDR_W(AW), .WB_LATENCY(WBL), .LOAD_USE_STALL(LUS), .STALL_CNT_W(SCW)
    ) dut (
        .clk(clk), .rst(rst), .src1(src1), .src2(src2), .Two_src(Two_src),
        .Issue_Valid(Issue_Valid), .Dest(Dest), .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN),
        .Forward_EN(Forward_EN), .Freeze(Freeze), .Flush(Flush),
        .Hazard(Hazard), .Stall_Cnt(Stall_Cnt)
    );

    always #5 clk = ~clk;

    function automatic bit m_busy(int r);
        return Forward_EN ? (m_ld[r] != 0) : (m_wb[r] != 0);
    endfunction

    function automatic bit m_hazard();
        return m_busy(int'(src1)) || (Two_src && m_busy(int'(src2)));
    endfunction

    function automatic void m_clear();
        for (int r = 0; r < NR; r++) begin
            m_wb[r] = 0;
            m_ld[r] = 0;
        end
        m_scnt = 0;
    endfunction

    // Advance the model with the current inputs, then cross the rising edge.
    task automatic tick();
        bit hz;
        bit acc;
        hz  = m_hazard();
        acc = Issue_Valid && !hz && !Freeze && !Flush;
        for (int r = 0; r < NR; r++) begin
            if (Flush) begin
                m_wb[r] = 0;
                m_ld[r] = 0;
            end else if (!Freeze) begin
                if (acc && WB_EN && int'(Dest) == r) begin
                    m_wb[r] = WBL;
                    m_ld[r] = MEM_R_EN ? LUS : 0;
                end else begin
                    if (m_wb[r] > 0) m_wb[r]--;
                    if (m_ld[r] > 0) m_ld[r]--;
                end
            end
        end
        if (hz && !Flush && m_scnt < SMAX) m_scnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        src1 = '0; src2 = '0; Dest = '0; Two_src = 1'b0; Issue_Valid = 1'b0;
        WB_EN = 1'b0; MEM_R_EN = 1'b0; Freeze = 1'b0; Flush = 1'b0;
    endtask

    task automatic do_reset(input bit fwd);
        idle_inputs();
        rst = 1'b0;
        Forward_EN = fwd;
        m_clear();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
    endtask

    task automatic issue(input int d, input bit ld);
        Issue_Valid = 1'b1; WB_EN = 1'b1; MEM_R_EN = ld; Dest = AW'(d);
        src1 = '0; src2 = '0; Two_src = 1'b0;
        #1;
        tick();
        Issue_Valid = 1'b0; WB_EN = 1'b0; MEM_R_EN = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        Forward_EN = 1'b0;
        rst = 1'b0;
        m_clear();
        #12;
        n_cmp++;
        if (Hazard !== 1'b0 || Stall_Cnt !== '0) begin
            n_fail++;
            $display("FAIL reset: Hazard=%b Stall_Cnt=%0d expected 0/0", Hazard, Stall_Cnt);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_raw_noforward();
        bit exp_hz[3] = '{1'b1, 1'b1, 1'b0};
        do_reset(1'b0);
        issue(3, 1'b0);
        src1 = 4'd3;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++;
            if (Hazard !== exp_hz[c]) begin
                n_fail++;
                $display("FAIL raw_c%0d: Hazard=%b expected %b", c + 1, Hazard, exp_hz[c]);
            end
            tick();
        end
        n_cmp++;
        if (Stall_Cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL raw_stall_cnt: Stall_Cnt=%0d expected 2", Stall_Cnt);
        end
    endtask

    task automatic test_load_use();
        do_reset(1'b1);
        issue(5, 1'b1);
        src2 = 4'd5; Two_src = 1'b1;
        #1;
        n_cmp++;
        if (Hazard !== 1'b1) begin
            n_fail++;
            $display("FAIL load_use_c1: Hazard=%b expected 1", Hazard);
        end
        tick();
        n_cmp++;
        if (Hazard !== 1'b0) begin
            n_fail++;
            $display("FAIL load_use_c2: Hazard=%b expected 0", Hazard);
        end
        issue(5, 1'b0);
        src2 = 4'd5; Two_src = 1'b1;
        #1;
        n_cmp++;
        if (Hazard !== 1'b0) begin
            n_fail++;
            $display("FAIL nonload_fwd: Hazard=%b expected 0", Hazard);
        end
    endtask

    task automatic test_two_src();
        do_reset(1'b0);
        issue(7, 1'b0);
        src1 = 4'd0; src2 = 4'd7; Two_src = 1'b0;
        #1;
        n_cmp++;
        if (Hazard !== 1'b0) begin
            n_fail++;
            $display("FAIL two_src_off: Hazard=%b expected 0", Hazard);
        end
        Two_src = 1'b1;
        #1;
        n_cmp++;
        if (Hazard !== 1'b1) begin
            n_fail++;
            $display("FAIL two_src_on: Hazard=%b expected 1", Hazard);
        end
        src1 = 4'd7; src2 = 4'd0; Two_src = 1'b0;
        #1;
        n_cmp++;
        if (Hazard !== 1'b1) begin
            n_fail++;
            $display("FAIL src1_always: Hazard=%b expected 1", Hazard);
        end
    endtask

    task automatic test_freeze_flush();
        do_reset(1'b0);
        issue(2, 1'b0);
        src1 = 4'd2; Freeze = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++;
            if (Hazard !== 1'b1) begin
                n_fail++;
                $display("FAIL freeze_hold_c%0d: Hazard=%b expected 1", c, Hazard);
            end
            tick();
        end
        n_cmp++;
        if (Stall_Cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL freeze_count: Stall_Cnt=%0d expected 3", Stall_Cnt);
        end
        Freeze = 1'b0; Flush = 1'b1;
        tick();
        Flush = 1'b0;
        #1;
        n_cmp++;
        if (Hazard !== 1'b0 || Stall_Cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL flush: Hazard=%b Stall_Cnt=%0d expected 0/3", Hazard, Stall_Cnt);
        end
    endtask

    task automatic test_overwrite();
        bit exp_hz[3] = '{1'b1, 1'b1, 1'b0};
        do_reset(1'b0);
        issue(4, 1'b0);
        issue(4, 1'b1);
        src1 = 4'd4;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++;
            if (Hazard !== exp_hz[c]) begin
                n_fail++;
                $display("FAIL overwrite_c%0d: Hazard=%b expected %b", c, Hazard, exp_hz[c]);
            end
            tick();
        end
    endtask

    task automatic test_random();
        do_reset(1'($urandom_range(0, 1)));
        for (int c = 0; c < 400; c++) begin
            src1        = AW'($urandom_range(0, 5));
            src2        = AW'($urandom_range(0, 5));
            Two_src     = 1'($urandom_range(0, 1));
            Issue_Valid = ($urandom_range(0, 3) != 0);
            Dest        = AW'($urandom_range(0, 5));
            WB_EN       = ($urandom_range(0, 3) != 0);
            MEM_R_EN    = 1'($urandom_range(0, 1));
            Freeze      = ($urandom_range(0, 9) == 0);
            Flush       = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 49) == 0) Forward_EN = ~Forward_EN;
            #1;
            n_cmp++;
            if (Hazard !== m_hazard() || int'(Stall_Cnt) != m_scnt) begin
                n_fail++;
                $display("FAIL random_c%0d: Hazard=%b Stall_Cnt=%0d expected %b/%0d",
                         c, Hazard, Stall_Cnt, m_hazard(), m_scnt);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_saturation();
        do_reset(1'b0);
        issue(1, 1'b0);
        src1 = 4'd1; Freeze = 1'b1;
        for (int c = 0; c < SMAX + 6; c++) tick();
        n_cmp++;
        if (Stall_Cnt !== 16'hFFFF || int'(Stall_Cnt) != m_scnt) begin
            n_fail++;
            $display("FAIL saturation: Stall_Cnt=%h expected ffff", Stall_Cnt);
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        do_reset(1'b0);
        issue(6, 1'b0);
        src1 = 4'd6;
        tick();
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (Hazard !== 1'b0 || Stall_Cnt !== '0) begin
            n_fail++;
            $display("FAIL async_reset: Hazard=%b Stall_Cnt=%0d expected 0/0", Hazard, Stall_Cnt);
        end
        m_clear();
        #3;
        rst = 1'b1;
        #1;
        for (int c = 0; c < 4; c++) begin
            src1 = AW'($urandom_range(0, NR - 1));
            #1;
            n_cmp++;
            if (Hazard !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_c%0d: Hazard=%b expected 0", c, Hazard);
            end
        end
    endtask

    initial begin
        test_reset();
        test_raw_noforward();
        test_load_use();
        test_two_src();
        test_freeze_flush();
        test_overwrite();
        test_random();
        test_random();
        test_saturation();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
